// File: rtl/seq_signed_mult_if.sv
// Handshake bundle for seq_signed_mult: operand channel in, product channel out.
// The master side is the producer/consumer; the slave side is the multiplier.
interface seq_signed_mult_if #(
   parameter int WIDTH = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   signed_mode;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     r;
   logic                   busy;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, r, busy
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, r, busy
   );
endinterface

// File: rtl/seq_signed_mult.sv
// Area-lean radix-2 shift-add multiplier on operand magnitudes, one multiplier
// bit per cycle, with a two's-complement sign fix on the final cycle.
module seq_signed_mult #(
   parameter  int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_signed_mult_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sign_q, sign_d;
   logic [2*WIDTH-1:0]   r_q, r_d;

   logic [WIDTH:0]       acc_sum;
   logic [2*WIDTH-1:0]   acc_step;

   // |x| only for negative two's-complement inputs; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] val,
                                                  input logic             is_signed);
      if (is_signed && val[WIDTH-1])
         return ~val + WIDTH'(1);
      return val;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                     input logic               neg);
      if (neg)
         return ~mag + (2*WIDTH)'(1);
      return mag;
   endfunction

   // Right-shifting accumulator: add into the upper half, then shift the
   // whole product one place; after WIDTH steps it holds the full magnitude.
   always_comb begin
      acc_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
      acc_step = {acc_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      r_d      = r_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               mcand_d  = magnitude(bus.a, bus.signed_mode);
               mplier_d = magnitude(bus.b, bus.signed_mode);
               sign_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               r_d     = apply_sign(acc_step, sign_q);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         r_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         r_q      <= r_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.r         = r_q;

endmodule

// File: tb/tb_seq_signed_mult.sv
// Directed and random checks of seq_signed_mult against a cycle-level
// behavioural model plus literal expected products.
module tb_seq_signed_mult;
   localparam int W = 16;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   seq_signed_mult_if #(.WIDTH(W)) bus ();

   seq_signed_mult #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sm);
      longint p;
      if (sm) p = longint'($signed(x)) * longint'($signed(y));
      else    p = longint'(x) * longint'(y);
      return p[2*W-1:0];
   endfunction

   // Model: a transaction occupies the block from acceptance until its result
   // is taken; the result appears W cycles after acceptance.
   initial begin
      bit            m_busy;
      int            m_left;
      logic [2*W-1:0] m_exp;
      logic [2*W-1:0] m_r;
      m_busy = 0; m_left = 0; m_exp = '0; m_r = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_busy = 0; m_left = 0; m_r = '0;
         end
         check("mdl_in_ready",  bus.in_ready,  !m_busy);
         check("mdl_out_valid", bus.out_valid, m_busy && m_left == 0);
         check("mdl_busy",      bus.busy,      m_busy);
         check("mdl_r",         bus.r,         m_r);
         if (rst_n) begin
            if (!m_busy) begin
               if (bus.in_valid) begin
                  m_busy = 1;
                  m_left = W;
                  m_exp  = ref_prod(bus.a, bus.b, bus.signed_mode);
               end
            end else if (m_left > 0) begin
               m_left--;
               if (m_left == 0) m_r = m_exp;
            end else if (bus.out_ready) begin
               m_busy = 0;
            end
         end
      end
   end

   // Issue one transaction from an idle point (posedge+2), check latency and
   // product, optionally stall the consumer for 'hold' cycles, then drain.
   task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic sm,
                      input logic [2*W-1:0] exp, input int hold);
      int lat;
      bit got;
      bus.out_ready   = (hold == 0);
      bus.a           = ta;
      bus.b           = tb_;
      bus.signed_mode = sm;
      bus.in_valid    = 1'b1;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) begin got = 1; break; end
         @(posedge clk); #2;
      end
      check("ready_timeout", got, 1'b1);
      @(posedge clk); #2;
      bus.in_valid    = 1'b0;
      bus.a           = W'($urandom);
      bus.b           = W'($urandom);
      bus.signed_mode = ~sm;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #2;
         lat++;
      end
      check("latency", lat, 16);
      check("result", bus.r, exp);
      check("in_ready_done", bus.in_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #2;
         check("hold_valid", bus.out_valid, 1'b1);
         check("hold_r", bus.r, exp);
         check("hold_in_ready", bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #2;
      check("release_valid", bus.out_valid, 1'b0);
      check("release_in_ready", bus.in_ready, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int   acc_t[$];
      bit   rdy;
      bit   idle;
      logic [W-1:0] ra, rb;
      logic         rs;
      int           hold;

      n_vec = 0; n_err = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
      bus.signed_mode = 1'b0; bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #2;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_r", bus.r, '0);
      check("rst_busy", bus.busy, 1'b0);
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (50) @(posedge clk);
      #2;
      check("idle_in_ready", bus.in_ready, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_r", bus.r, '0);

      run(16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB, 0);
      run(16'hFFFD, 16'hFFF9, 1'b1, 32'h0000_0015, 0);
      run(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 0);
      run(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 0);
      run(16'h0000, 16'h8000, 1'b1, 32'h0000_0000, 0);
      run(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0);
      run(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 0);
      run(16'h1234, 16'hFFFE, 1'b1, 32'hFFFF_DB98, 10);
      run(16'h1234, 16'hFFFE, 1'b0, 32'h1233_DB98, 3);

      // Continuous demand with a free-running consumer.
      bus.a = 16'h0101; bus.b = 16'h0202; bus.signed_mode = 1'b0;
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) acc_t.push_back(i);
         #2;
      end
      bus.in_valid = 1'b0;
      check("b2b_accepts", acc_t.size(), 4);
      for (int k = 1; k < acc_t.size(); k++)
         check("b2b_interval", acc_t[k] - acc_t[k-1], 18);
      idle = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.in_ready) begin idle = 1; break; end
         @(posedge clk); #2;
      end
      check("b2b_drain", idle, 1'b1);

      // Asynchronous reset five cycles into a calculation.
      bus.a = 16'h1234; bus.b = 16'h5678; bus.signed_mode = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_in_ready", bus.in_ready, 1'b1);
      check("arst_out_valid", bus.out_valid, 1'b0);
      check("arst_busy", bus.busy, 1'b0);
      check("arst_r", bus.r, '0);
      @(negedge clk);
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #2;
      run(16'h0002, 16'h0003, 1'b1, 32'h0000_0006, 0);

      for (int v = 0; v < 2000; v++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         run(ra, rb, rs, ref_prod(ra, rb, rs), hold);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
